tensor_ctrl: RTL

TENSOR_CTRL -- requirements
Module: tensor_ctrl

---
 rtl/tensor_ctrl_if.sv | 45 ++++
 rtl/tensor_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/tensor_ctrl_if.sv
// Bundle of warp request, datapath step and commit signals for tensor_ctrl.
// slave is the controller side; master is the side that drives requests and models the datapath.
interface tensor_ctrl_if #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_STEPS = 4,
  parameter int UUID_W    = 44
);
  localparam int NR_BITS = 5;
  localparam int NW_W    = $clog2(NUM_WARPS);
  localparam int SW      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic [NUM_WARPS-1:0]         req_valid;
  logic [NUM_WARPS-1:0]         req_ready;
  logic [NUM_WARPS*NR_BITS-1:0] req_rd;
  logic [NUM_WARPS-1:0]         req_wb;
  logic [NUM_WARPS*UUID_W-1:0]  req_uuid;

  logic          dp_valid;
  logic          dp_ready;
  logic [SW-1:0] dp_step;
  logic          dp_first;
  logic          dp_last;
  logic          dp_done;

  logic               cmt_valid;
  logic               cmt_ready;
  logic [NW_W-1:0]    cmt_wid;
  logic [NR_BITS-1:0] cmt_rd;
  logic               cmt_wb;
  logic [UUID_W-1:0]  cmt_uuid;

  logic busy;

  modport slave (
    input  req_valid, req_rd, req_wb, req_uuid, dp_ready, dp_done, cmt_ready,
    output req_ready, dp_valid, dp_step, dp_first, dp_last,
           cmt_valid, cmt_wid, cmt_rd, cmt_wb, cmt_uuid, busy
  );

  modport master (
    output req_valid, req_rd, req_wb, req_uuid, dp_ready, dp_done, cmt_ready,
    input  req_ready, dp_valid, dp_step, dp_first, dp_last,
           cmt_valid, cmt_wid, cmt_rd, cmt_wb, cmt_uuid, busy
  );
endinterface

// File: rtl/tensor_ctrl.sv
// Single-issue MMA sequencer: round-robin warp grant, NUM_STEPS k-step beats to the
// tensor datapath, wait for the result, then commit the latched tags to writeback.
module tensor_ctrl #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_STEPS = 4,
  parameter int UUID_W    = 44
) (
  input logic           clk,
  input logic           reset,
  tensor_ctrl_if.slave  bus
);
  localparam int NR_BITS = 5;
  localparam int NW_W    = $clog2(NUM_WARPS);
  localparam int SW      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

  typedef struct packed {
    logic [NW_W-1:0]    wid;
    logic [NR_BITS-1:0] rd;
    logic               wb;
    logic [UUID_W-1:0]  uuid;
  } tag_t;

  state_t          state, state_nx;
  tag_t            tag;
  logic [NW_W-1:0] rr_ptr, gnt_idx, scan_idx;
  logic [SW-1:0]   step;
  logic            gnt_found, grant_fire, step_last;

  // First valid warp at or after rr_ptr; NUM_WARPS is a power of two so the add wraps.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int off = 0; off < NUM_WARPS; off++) begin
      scan_idx = rr_ptr + NW_W'(off);
      if (!gnt_found && bus.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign grant_fire = (state == IDLE) && !reset && gnt_found;
  assign step_last  = (step == SW'(NUM_STEPS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_fire)                 state_nx = ISSUE;
      ISSUE:   if (bus.dp_ready && step_last)  state_nx = WAIT;
      WAIT:    if (bus.dp_done)                state_nx = COMMIT;
      COMMIT:  if (bus.cmt_ready)              state_nx = IDLE;
      default:                                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      step   <= '0;
      tag    <= '0;
    end else begin
      if (grant_fire) begin
        tag.wid  <= gnt_idx;
        tag.rd   <= bus.req_rd[int'(gnt_idx)*NR_BITS +: NR_BITS];
        tag.wb   <= bus.req_wb[gnt_idx];
        tag.uuid <= bus.req_uuid[int'(gnt_idx)*UUID_W +: UUID_W];
        rr_ptr   <= gnt_idx + NW_W'(1);
        step     <= '0;
      end
      if (state == ISSUE && bus.dp_ready && !step_last)
        step <= step + SW'(1);
    end
  end

  // Everything is forced low while reset is high, even before the first reset edge lands.
  always_comb begin
    bus.req_ready = '0;
    bus.dp_valid  = 1'b0;
    bus.dp_step   = '0;
    bus.dp_first  = 1'b0;
    bus.dp_last   = 1'b0;
    bus.cmt_valid = 1'b0;
    bus.cmt_wid   = '0;
    bus.cmt_rd    = '0;
    bus.cmt_wb    = 1'b0;
    bus.cmt_uuid  = '0;
    bus.busy      = 1'b0;
    if (!reset) begin
      if (grant_fire) bus.req_ready[gnt_idx] = 1'b1;
      case (state)
        ISSUE: begin
          bus.dp_valid = 1'b1;
          bus.dp_step  = step;
          bus.dp_first = (step == '0);
          bus.dp_last  = step_last;
        end
        COMMIT:  bus.cmt_valid = 1'b1;
        default: ;
      endcase
      bus.busy     = (state != IDLE);
      bus.cmt_wid  = tag.wid;
      bus.cmt_rd   = tag.rd;
      bus.cmt_wb   = tag.wb;
      bus.cmt_uuid = tag.uuid;
    end
  end
endmodule
